// File: rtl/bus_src_mux_if.sv
// rtl/bus_src_mux_if.sv - source-select request and registered bus result signals
interface bus_src_mux_if #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 4,
    parameter int SELW  = 3
);
    logic [NSRC*WIDTH-1:0] src_data;
    logic [SELW-1:0]       sel;
    logic                  srcoe;
    logic                  err_clr;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_drive;
    logic [SELW-1:0]       bus_owner;
    logic                  sel_err;

    modport master (
        output src_data, sel, srcoe, err_clr,
        input  bus_out, bus_drive, bus_owner, sel_err
    );

    modport slave (
        input  src_data, sel, srcoe, err_clr,
        output bus_out, bus_drive, bus_owner, sel_err
    );
endinterface

// File: rtl/bus_src_mux.sv
// rtl/bus_src_mux.sv - registered bus source multiplexer with optional turnaround cycle
module bus_src_mux #(
    parameter int WIDTH      = 8,
    parameter int NSRC       = 4,
    parameter int SELW       = 3,
    parameter int TURNAROUND = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_src_mux_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    localparam logic [SELW-1:0] MAX_SEL = SELW'(NSRC);

    state_t            state, state_n;
    logic [WIDTH-1:0]  out_q, out_n;
    logic              drive_q, drive_n;
    logic [SELW-1:0]   owner_q, owner_n;
    logic [SELW-1:0]   pend_q, pend_n;
    logic              err_q, err_n;
    logic [WIDTH-1:0]  ch_sel, ch_pend;
    logic              sel_legal, sel_illegal;

    // Channels are matched by comparison so out-of-range codes never index src_data.
    always_comb begin
        ch_sel  = '0;
        ch_pend = '0;
        for (int k = 1; k <= NSRC; k++) begin
            if (bus.sel == SELW'(k))
                ch_sel = bus.src_data[k*WIDTH-1 -: WIDTH];
            if (pend_q == SELW'(k))
                ch_pend = bus.src_data[k*WIDTH-1 -: WIDTH];
        end
    end

    assign sel_legal   = bus.srcoe && (bus.sel != '0) && (bus.sel <= MAX_SEL);
    assign sel_illegal = bus.srcoe && (bus.sel > MAX_SEL);

    always_comb begin
        state_n = state;
        out_n   = out_q;
        drive_n = drive_q;
        owner_n = owner_q;
        pend_n  = pend_q;
        unique case (state)
            IDLE: begin
                out_n   = '0;
                drive_n = 1'b0;
                owner_n = '0;
                if (sel_legal) begin
                    state_n = DRIVE;
                    out_n   = ch_sel;
                    drive_n = 1'b1;
                    owner_n = bus.sel;
                end
            end
            DRIVE: begin
                if (bus.srcoe) begin
                    if (bus.sel == owner_q) begin
                        out_n = ch_sel;
                    end else if (!sel_legal) begin
                        state_n = IDLE;
                        out_n   = '0;
                        drive_n = 1'b0;
                        owner_n = '0;
                    end else if (TURNAROUND != 0) begin
                        state_n = TURN;
                        out_n   = '0;
                        drive_n = 1'b0;
                        owner_n = '0;
                        pend_n  = bus.sel;
                    end else begin
                        out_n   = ch_sel;
                        owner_n = bus.sel;
                    end
                end
            end
            TURN: begin
                state_n = DRIVE;
                out_n   = ch_pend;
                drive_n = 1'b1;
                owner_n = pend_q;
                pend_n  = '0;
            end
            default: begin
                state_n = IDLE;
                out_n   = '0;
                drive_n = 1'b0;
                owner_n = '0;
                pend_n  = '0;
            end
        endcase
    end

    // A set request in the same cycle as a clear leaves the flag set.
    assign err_n = sel_illegal ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            out_q   <= '0;
            drive_q <= 1'b0;
            owner_q <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            out_q   <= out_n;
            drive_q <= drive_n;
            owner_q <= owner_n;
            pend_q  <= pend_n;
            err_q   <= err_n;
        end
    end

    assign bus.bus_out   = out_q;
    assign bus.bus_drive = drive_q;
    assign bus.bus_owner = owner_q;
    assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_bus_src_mux.sv
// tb/tb_bus_src_mux.sv - scoreboard bench for bus_src_mux (turnaround, direct, wide variants)
module tb_bus_src_mux;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_src_mux_if #(.WIDTH(8),  .NSRC(4), .SELW(3)) if_a ();
    bus_src_mux_if #(.WIDTH(8),  .NSRC(4), .SELW(3)) if_b ();
    bus_src_mux_if #(.WIDTH(16), .NSRC(7), .SELW(3)) if_c ();

    bus_src_mux #(.WIDTH(8),  .NSRC(4), .SELW(3), .TURNAROUND(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    bus_src_mux #(.WIDTH(8),  .NSRC(4), .SELW(3), .TURNAROUND(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    bus_src_mux #(.WIDTH(16), .NSRC(7), .SELW(3), .TURNAROUND(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    int vectors = 0;
    int miscompares = 0;
    logic [20:0] exp_q[$];

    // exp = {pad, drive, owner, bus_out, sel_err}
    typedef struct packed {
        logic        rst;
        logic        oe;
        logic [2:0]  sel;
        logic        clr;
        logic [31:0] data;
        logic [20:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic oe, input logic [2:0] sel,
                                input logic clr, input logic [31:0] data, input logic drv,
                                input logic [2:0] own, input logic [7:0] out, input logic err);
        vec_t v;
        v.rst  = rst;
        v.oe   = oe;
        v.sel  = sel;
        v.clr  = clr;
        v.data = data;
        v.exp  = {8'h00, drv, own, out, err};
        return v;
    endfunction

    function automatic logic [20:0] obs(input int dut);
        case (dut)
            0:       return {8'h00, if_a.bus_drive, if_a.bus_owner, if_a.bus_out, if_a.sel_err};
            1:       return {8'h00, if_b.bus_drive, if_b.bus_owner, if_b.bus_out, if_b.sel_err};
            default: return {if_c.bus_drive, if_c.bus_owner, if_c.bus_out, if_c.sel_err};
        endcase
    endfunction

    task automatic apply(input int dut, input vec_t v);
        @(negedge clk);
        rst_n = v.rst;
        if (dut == 0) begin
            if_a.srcoe = v.oe; if_a.sel = v.sel; if_a.err_clr = v.clr; if_a.src_data = v.data;
        end else begin
            if_b.srcoe = v.oe; if_b.sel = v.sel; if_b.err_clr = v.clr; if_b.src_data = v.data;
        end
        exp_q.push_back(v.exp);
    endtask

    task automatic test_reset();
        logic [20:0] e, got;
        @(negedge clk);
        rst_n = 1'b0;
        if_a.srcoe = 1'b1; if_a.sel = 3'd5; if_a.src_data = 32'hFFFF_FFFF;
        if_c.srcoe = 1'b1; if_c.sel = 3'd3; if_c.src_data = '1;
        exp_q.push_back(21'h0);
        exp_q.push_back(21'h0);
        @(posedge clk); #1;
        got = obs(0); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reset_a: got %h expected %h", got, e); end
        got = obs(2); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reset_c: got %h expected %h", got, e); end
        @(negedge clk);
        if_a.srcoe = 1'b0; if_a.sel = '0; if_a.src_data = '0;
        if_c.srcoe = 1'b0; if_c.sel = '0; if_c.src_data = '0;
        rst_n = 1'b1;
    endtask

    task automatic run_table(input string name, input int dut, input vec_t t[$]);
        logic [20:0] e, got;
        foreach (t[i]) begin
            apply(dut, t[i]);
            @(posedge clk); #1;
            got = obs(dut); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s step %0d: got %h expected %h", name, i, got, e);
            end
        end
    endtask

    task automatic test_drive();
        vec_t t[$];
        t.push_back(mk(1, 1, 2, 0, 32'h0000_A500, 1, 2, 8'hA5, 0));
        t.push_back(mk(1, 1, 2, 0, 32'h0000_3C00, 1, 2, 8'h3C, 0));
        run_table("drive", 0, t);
    endtask

    task automatic test_hold();
        vec_t t[$];
        t.push_back(mk(1, 1, 0, 0, 32'h0000_0000, 0, 0, 8'h00, 0));
        t.push_back(mk(1, 1, 1, 0, 32'h0000_0011, 1, 1, 8'h11, 0));
        t.push_back(mk(1, 0, 1, 0, 32'h0000_0022, 1, 1, 8'h11, 0));
        t.push_back(mk(1, 0, 3, 0, 32'h0000_0022, 1, 1, 8'h11, 0));
        run_table("hold", 0, t);
    endtask

    task automatic test_turnaround();
        vec_t t[$];
        t.push_back(mk(1, 1, 3, 0, 32'h0077_0022, 0, 0, 8'h00, 0));
        t.push_back(mk(1, 1, 2, 0, 32'h0077_5522, 1, 3, 8'h77, 0));
        t.push_back(mk(1, 1, 3, 0, 32'h0078_0000, 1, 3, 8'h78, 0));
        run_table("turnaround", 0, t);
    endtask

    task automatic test_direct_switch();
        vec_t t[$];
        t.push_back(mk(1, 1, 1, 0, 32'h0000_0011, 1, 1, 8'h11, 0));
        t.push_back(mk(1, 1, 3, 0, 32'h0077_0011, 1, 3, 8'h77, 0));
        t.push_back(mk(1, 1, 3, 0, 32'h0079_0011, 1, 3, 8'h79, 0));
        run_table("direct_switch", 1, t);
    endtask

    task automatic test_sel_err();
        vec_t t[$];
        t.push_back(mk(1, 1, 0, 0, 32'h0000_0000, 0, 0, 8'h00, 0));
        t.push_back(mk(1, 1, 4, 0, 32'h4400_0000, 1, 4, 8'h44, 0));
        t.push_back(mk(1, 1, 6, 0, 32'h4400_0000, 0, 0, 8'h00, 1));
        t.push_back(mk(1, 1, 7, 1, 32'h0000_0000, 0, 0, 8'h00, 1));
        t.push_back(mk(1, 0, 7, 1, 32'h0000_0000, 0, 0, 8'h00, 0));
        t.push_back(mk(1, 1, 1, 0, 32'h0000_0011, 1, 1, 8'h11, 0));
        t.push_back(mk(1, 1, 2, 0, 32'h0000_2211, 0, 0, 8'h00, 0));
        t.push_back(mk(1, 1, 5, 0, 32'h0000_2211, 1, 2, 8'h22, 1));
        t.push_back(mk(1, 0, 0, 1, 32'h0000_2211, 1, 2, 8'h22, 0));
        run_table("sel_err", 0, t);
    endtask

    task automatic test_reset_abort();
        vec_t t[$];
        t.push_back(mk(1, 1, 3, 0, 32'h0077_2200, 0, 0, 8'h00, 0));
        t.push_back(mk(0, 0, 0, 0, 32'h0077_2200, 0, 0, 8'h00, 0));
        t.push_back(mk(1, 0, 3, 0, 32'h0077_2200, 0, 0, 8'h00, 0));
        t.push_back(mk(1, 0, 3, 0, 32'h0077_2200, 0, 0, 8'h00, 0));
        t.push_back(mk(1, 1, 1, 0, 32'h0077_225A, 1, 1, 8'h5A, 0));
        run_table("reset_abort", 0, t);
    endtask

    task automatic test_sweep();
        logic [20:0] e, got;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            for (int j = 0; j < 7; j++) if_c.src_data[j*16 +: 16] = 16'h1000 + 16'(j + 1);
            if_c.srcoe = 1'b1; if_c.sel = 3'(k); if_c.err_clr = 1'b0;
            exp_q.push_back({1'b1, 3'(k), 16'h1000 + 16'(k), 1'b0});
            @(posedge clk); #1;
            got = obs(2); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL sweep_ch%0d: got %h expected %h", k, got, e); end
            @(negedge clk);
            if_c.sel = 3'd0;
            exp_q.push_back(21'h0);
            @(posedge clk); #1;
            got = obs(2); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL sweep_release%0d: got %h expected %h", k, got, e); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if_a.srcoe = 1'b0; if_a.sel = '0; if_a.err_clr = 1'b0; if_a.src_data = '0;
        if_b.srcoe = 1'b0; if_b.sel = '0; if_b.err_clr = 1'b0; if_b.src_data = '0;
        if_c.srcoe = 1'b0; if_c.sel = '0; if_c.err_clr = 1'b0; if_c.src_data = '0;
        test_reset();
        test_drive();
        test_hold();
        test_turnaround();
        test_direct_switch();
        test_sel_err();
        test_reset_abort();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
